switch_event_scheduler: RTL and testbench

- Collects one-cycle event pulses from the synchronized switch channels (sw1..sw5 after synchronization/pulse generation).
- Holds each event in a per-channel pending bit and serves the events one at a time to a single downstream consumer over a valid/ready handshake.
- Uses round-robin arbitration and enforces a programmable lockout gap between served events.
- Counts events lost because their channel already had an event pending.

---
 rtl/switch_event_scheduler.sv | 171 +++++++++++++++++
 tb/tb_switch_event_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : switch_event_scheduler
// Description : Latches one-cycle switch event pulses into per-channel pending
//               bits and serves them one at a time to a single consumer over a
//               valid/ready handshake. Arbitration is round-robin, a
//               programmable lockout gap follows every accepted event, and
//               events lost to an already-pending channel are counted.
// Ports       : clk       - system clock, rising edge
//               reset     - synchronous active-high reset
//               sw_pulse  - one-cycle event pulses, bit i = channel i
//               enable    - permits new offers (events still latch when low)
//               ev_valid  - event offered to consumer
//               ev_ready  - consumer accepts offered event
//               ev_id     - channel index of offered event
//               pending   - registered pending bits
//               drop_cnt  - saturating count of dropped events
//               busy      - high whenever the scheduler is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module switch_event_scheduler #(
    parameter int N_CH       = 5,
    parameter int ID_W       = 3,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   sw_pulse,
    input  logic              enable,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [ID_W-1:0]   ev_id,
    output logic [N_CH-1:0]   pending,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy
);

    localparam int                 c_GAP_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]    c_LAST_INIT = ID_W'(N_CH - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD  = c_GAP_W'(GAP_CYCLES);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE   = c_GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              r_state_q,      w_state_d;
    logic [N_CH-1:0]     r_pending_q,    w_pending_d;
    logic [CNT_W-1:0]    r_drop_cnt_q,   w_drop_cnt_d;
    logic                r_ev_valid_q,   w_ev_valid_d;
    logic [ID_W-1:0]     r_ev_id_q,      w_ev_id_d;
    logic [ID_W-1:0]     r_last_grant_q, w_last_grant_d;
    logic [c_GAP_W-1:0]  r_gap_cnt_q,    w_gap_cnt_d;

    logic                w_accept;
    logic [N_CH-1:0]     w_clear;
    logic [3:0]          w_drop_num;
    logic [CNT_W+3:0]    w_drop_sum;
    logic [ID_W-1:0]     w_sel;
    int                  w_best;
    int                  w_dist;

    assign w_accept = r_ev_valid_q & ev_ready;

    // Pending latch and drop counting. A pulse landing on the same cycle as
    // its channel's handshake is a fresh event, so it is retained, not dropped.
    always_comb begin
        w_clear    = '0;
        w_drop_num = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_clear[i] = w_accept && (r_ev_id_q == ID_W'(i));
            if (sw_pulse[i] && r_pending_q[i] && !w_clear[i]) begin
                w_drop_num = w_drop_num + 4'd1;
            end
        end
        w_pending_d = (r_pending_q & ~w_clear) | sw_pulse;
        w_drop_sum  = {4'b0, r_drop_cnt_q} + {CNT_W'(0), w_drop_num};
        if (w_drop_sum > {4'b0, c_CNT_MAX}) begin
            w_drop_cnt_d = c_CNT_MAX;
        end else begin
            w_drop_cnt_d = w_drop_sum[CNT_W-1:0];
        end
    end

    // Round-robin pick: the pending channel with the smallest distance past
    // last_grant (modulo N_CH) wins.
    always_comb begin
        w_sel  = '0;
        w_best = N_CH;
        w_dist = 0;
        for (int i = 0; i < N_CH; i++) begin
            w_dist = (i + N_CH - 1 - int'(r_last_grant_q)) % N_CH;
            if (r_pending_q[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_sel  = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_ev_valid_d   = r_ev_valid_q;
        w_ev_id_d      = r_ev_id_q;
        w_last_grant_d = r_last_grant_q;
        w_gap_cnt_d    = r_gap_cnt_q;
        case (r_state_q)
            S_IDLE: begin
                if (enable && (r_pending_q != '0)) begin
                    w_ev_id_d    = w_sel;
                    w_ev_valid_d = 1'b1;
                    w_state_d    = S_OFFER;
                end
            end
            S_OFFER: begin
                // Offer is never retracted; only a handshake ends it.
                if (w_accept) begin
                    w_ev_valid_d   = 1'b0;
                    w_last_grant_d = r_ev_id_q;
                    if (GAP_CYCLES > 0) begin
                        w_gap_cnt_d = c_GAP_LOAD;
                        w_state_d   = S_GAP;
                    end else begin
                        w_state_d   = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                w_gap_cnt_d = r_gap_cnt_q - c_GAP_ONE;
                if (r_gap_cnt_q == c_GAP_ONE) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d    = S_IDLE;
                w_ev_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_pending_q    <= '0;
            r_drop_cnt_q   <= '0;
            r_ev_valid_q   <= 1'b0;
            r_ev_id_q      <= '0;
            r_last_grant_q <= c_LAST_INIT;
            r_gap_cnt_q    <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_pending_q    <= w_pending_d;
            r_drop_cnt_q   <= w_drop_cnt_d;
            r_ev_valid_q   <= w_ev_valid_d;
            r_ev_id_q      <= w_ev_id_d;
            r_last_grant_q <= w_last_grant_d;
            r_gap_cnt_q    <= w_gap_cnt_d;
        end
    end

    assign ev_valid = r_ev_valid_q;
    assign ev_id    = r_ev_id_q;
    assign pending  = r_pending_q;
    assign drop_cnt = r_drop_cnt_q;
    assign busy     = (r_state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_switch_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_event_scheduler
// Description : Self-checking bench for switch_event_scheduler. A behavioural
//               model tracks pending events, the current offer and the lockout
//               countdown; directed scenarios pin literal values, then a long
//               randomized run is compared cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_event_scheduler;

    localparam int N_CH    = 5;
    localparam int ID_W    = 3;
    localparam int GAP     = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N_CH-1:0]   sw_pulse = '0;
    logic              enable = 1'b0;
    logic              ev_ready = 1'b0;
    logic              ev_valid;
    logic [ID_W-1:0]   ev_id;
    logic [N_CH-1:0]   pending;
    logic [CNT_W-1:0]  drop_cnt;
    logic              busy;

    always #5 clk = ~clk;

    switch_event_scheduler #(
        .N_CH       (N_CH),
        .ID_W       (ID_W),
        .GAP_CYCLES (GAP),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .sw_pulse (sw_pulse),
        .enable   (enable),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_id    (ev_id),
        .pending  (pending),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    int n_err = 0;
    int n_chk = 0;
    bit chk_on = 1'b0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_wait counts lockout cycles still to run before a new offer may form.
    logic [N_CH-1:0] m_pend = '0;
    logic [N_CH-1:0] m_next;
    int  m_drop = 0;
    int  m_last = N_CH - 1;
    int  m_wait = 0;
    int  m_id   = 0;
    int  m_c;
    bit  m_valid = 1'b0;
    bit  m_acc;
    bit  m_found;

    always @(posedge clk) begin
        if (reset) begin
            m_pend  = '0;
            m_drop  = 0;
            m_last  = N_CH - 1;
            m_wait  = 0;
            m_valid = 1'b0;
            m_id    = 0;
        end else begin
            m_acc  = m_valid && ev_ready;
            m_next = m_pend;
            for (int i = 0; i < N_CH; i++) begin
                if (m_acc && m_id == i) m_next[i] = 1'b0;
                if (sw_pulse[i]) begin
                    if (m_next[i]) m_drop = (m_drop < CNT_MAX) ? m_drop + 1 : CNT_MAX;
                    m_next[i] = 1'b1;
                end
            end
            if (m_acc) begin
                m_valid = 1'b0;
                m_last  = m_id;
                m_wait  = GAP;
            end else if (m_valid) begin
                m_valid = 1'b1;
            end else if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end else if (enable && m_pend != '0) begin
                m_found = 1'b0;
                for (int k = 1; k <= N_CH; k++) begin
                    m_c = (m_last + k) % N_CH;
                    if (!m_found && (((m_pend >> m_c) & 1) != 0)) begin
                        m_found = 1'b1;
                        m_id    = m_c;
                    end
                end
                m_valid = 1'b1;
            end
            m_pend = m_next;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("ev_valid", int'(ev_valid), int'(m_valid));
            if (m_valid) cmp("ev_id", int'(ev_id), m_id);
            cmp("pending", int'(pending), int'(m_pend));
            cmp("drop_cnt", int'(drop_cnt), m_drop);
            cmp("busy", int'(busy), int'(m_valid || m_wait > 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (ev_valid !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        cmp("wait_valid", int'(ev_valid), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    int n;
    int prev;
    int cyc;
    int got;

    initial begin
        step();
        chk_on = 1'b1;
        step();
        reset = 1'b0;

        // Reset state
        cmp("rst_valid", int'(ev_valid), 0);
        cmp("rst_id", int'(ev_id), 0);
        cmp("rst_pending", int'(pending), 0);
        cmp("rst_drop", int'(drop_cnt), 0);
        cmp("rst_busy", int'(busy), 0);

        // Single event
        enable = 1'b1; ev_ready = 1'b1;
        sw_pulse = 5'b00100; step(); sw_pulse = '0;
        cmp("single_pend", int'(pending), 4);
        cmp("single_valid0", int'(ev_valid), 0);
        step();
        cmp("single_valid", int'(ev_valid), 1);
        cmp("single_id", int'(ev_id), 2);
        step();
        cmp("single_cleared", int'(pending), 0);
        cmp("single_dropvalid", int'(ev_valid), 0);
        for (int i = 0; i < GAP; i++) begin
            cmp("single_gap_busy", int'(busy), 1);
            step();
        end
        cmp("single_idle", int'(busy), 0);

        // Round-robin from fresh reset
        do_reset();
        sw_pulse = 5'b11111; step(); sw_pulse = '0;
        prev = 0; cyc = 0; got = 0;
        while (got < 5 && cyc < 100) begin
            if (ev_valid) begin
                cmp("rr_id", int'(ev_id), got);
                if (got > 0) cmp("rr_spacing", cyc - prev, GAP + 2);
                prev = cyc;
                got++;
            end
            step();
            cyc++;
        end
        cmp("rr_count", got, 5);
        sw_pulse = 5'b01001; step(); sw_pulse = '0;
        wait_valid(n);
        cmp("rr_wrap_id", int'(ev_id), 0);
        step();

        // Back-pressure with enable dropped during the wait
        do_reset();
        ev_ready = 1'b0;
        sw_pulse = 5'b01010; step(); sw_pulse = '0;
        wait_valid(n);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cmp("bp_valid", int'(ev_valid), 1);
            cmp("bp_id", int'(ev_id), 1);
            step();
        end
        ev_ready = 1'b1; step();
        cmp("bp_accepted", int'(ev_valid), 0);
        cmp("bp_pending", int'(pending), 8);
        repeat (8) step();
        cmp("bp_disabled", int'(ev_valid), 0);
        enable = 1'b1;
        wait_valid(n);
        cmp("bp_next_id", int'(ev_id), 3);
        step();

        // Collision: pulse on the handshake cycle of the same channel
        do_reset();
        ev_ready = 1'b0;
        sw_pulse = 5'b10000; step(); sw_pulse = '0;
        wait_valid(n);
        cmp("col_id", int'(ev_id), 4);
        ev_ready = 1'b1; sw_pulse = 5'b10000; step(); sw_pulse = '0;
        cmp("col_pending", int'(pending), 16);
        cmp("col_drop", int'(drop_cnt), 0);
        cmp("col_valid", int'(ev_valid), 0);
        wait_valid(n);
        cmp("col_gap_wait", n, GAP + 1);
        cmp("col_reoffer_id", int'(ev_id), 4);
        step();

        // Drops and saturation
        do_reset();
        enable = 1'b0;
        sw_pulse = 5'b00010; repeat (3) step(); sw_pulse = '0;
        step();
        cmp("drop_pending", int'(pending), 2);
        cmp("drop_cnt2", int'(drop_cnt), 2);
        sw_pulse = 5'b11111; repeat (60) step(); sw_pulse = '0;
        cmp("drop_sat", int'(drop_cnt), CNT_MAX);
        sw_pulse = 5'b11111; repeat (3) step(); sw_pulse = '0;
        step();
        cmp("drop_sat_hold", int'(drop_cnt), CNT_MAX);
        cmp("drop_no_offer", int'(ev_valid), 0);

        // Reset in the middle of an offer
        enable = 1'b1; ev_ready = 1'b0;
        sw_pulse = 5'b00111; step(); sw_pulse = '0;
        wait_valid(n);
        reset = 1'b1; step(); reset = 1'b0;
        cmp("mid_valid", int'(ev_valid), 0);
        cmp("mid_id", int'(ev_id), 0);
        cmp("mid_pending", int'(pending), 0);
        cmp("mid_drop", int'(drop_cnt), 0);
        cmp("mid_busy", int'(busy), 0);
        sw_pulse = 5'b10001; step(); sw_pulse = '0;
        wait_valid(n);
        cmp("mid_first_id", int'(ev_id), 0);
        ev_ready = 1'b1; step();

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 7) != 0);
            ev_ready = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < N_CH; i++) sw_pulse[i] = ($urandom_range(0, 9) == 0);
            step();
        end
        reset = 1'b0; sw_pulse = '0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
